// File: rtl/d_ff_strobe_ctrl.sv
// rtl/d_ff_strobe_ctrl.sv - clear burst then periodic enable strobes for the capture flop
module d_ff_strobe_ctrl #(
    parameter int DIV_W      = 8,
    parameter int CNT_W      = 8,
    parameter int CLR_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] period,
    input  logic [CNT_W-1:0] num_strobes,
    output logic             enable,
    output logic             clear_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] strobe_cnt
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CLR_W-1:0] clr_q, clr_d;
    logic             enable_q, enable_d;
    logic             clear_n_q, clear_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] strobe_cnt_q, strobe_cnt_d;
    logic [DIV_W-1:0] div_last;

    assign div_last = period_q - DIV_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (stop)                   state_d = S_IDLE;
                else if (clr_q == CLR_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                // strobe_cnt_q already includes the strobe showing on enable_q
                if (stop)
                    state_d = S_IDLE;
                else if (enable_q && (num_q != '0) && (strobe_cnt_q == num_q))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered
    always_comb begin
        period_d     = period_q;
        num_d        = num_q;
        div_d        = '0;
        clr_d        = '0;
        strobe_cnt_d = strobe_cnt_q;

        if (state_q == S_IDLE && state_d == S_CLEAR) begin
            period_d     = (period == '0) ? DIV_W'(1) : period;
            num_d        = num_strobes;
            strobe_cnt_d = '0;
        end
        if (state_q == S_CLEAR && state_d == S_CLEAR) begin
            clr_d = clr_q + CLR_W'(1);
        end
        if (state_q == S_RUN && state_d == S_RUN) begin
            div_d = (div_q == div_last) ? '0 : div_q + DIV_W'(1);
        end

        enable_d = (state_d == S_RUN) && (div_d == div_last);
        if (enable_d && (strobe_cnt_d != '1)) begin
            strobe_cnt_d = strobe_cnt_d + CNT_W'(1);
        end

        clear_n_d = (state_d != S_CLEAR);
        busy_d    = (state_d == S_CLEAR) || (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q     <= '0;
            num_q        <= '0;
            div_q        <= '0;
            clr_q        <= '0;
            enable_q     <= 1'b0;
            clear_n_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            strobe_cnt_q <= '0;
        end else begin
            period_q     <= period_d;
            num_q        <= num_d;
            div_q        <= div_d;
            clr_q        <= clr_d;
            enable_q     <= enable_d;
            clear_n_q    <= clear_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            strobe_cnt_q <= strobe_cnt_d;
        end
    end

    assign enable     = enable_q;
    assign clear_n    = clear_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign strobe_cnt = strobe_cnt_q;

endmodule

// File: tb/tb_d_ff_strobe_ctrl.sv
// tb/tb_d_ff_strobe_ctrl.sv - directed bench for d_ff_strobe_ctrl
module tb_d_ff_strobe_ctrl;

    localparam int CLR = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic [7:0] period;
    logic [7:0] num_strobes;
    logic       enable;
    logic       clear_n;
    logic       busy;
    logic       done;
    logic [7:0] strobe_cnt;

    int n_checks = 0;
    int n_errors = 0;

    d_ff_strobe_ctrl #(.DIV_W(8), .CNT_W(8), .CLR_CYCLES(CLR)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .num_strobes (num_strobes),
        .enable      (enable),
        .clear_n     (clear_n),
        .busy        (busy),
        .done        (done),
        .strobe_cnt  (strobe_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle 0 carries start; each later cycle c is sampled at its negedge.
    // Packed check word: {enable, clear_n, busy, done, strobe_cnt}.
    task automatic run_seq(input string name, input int p, input int n,
                           input int stop_at, input int dist_at, input int len);
        int   pe, first, last, end_busy, cnt;
        logic stopped, strb, e_clr, e_busy, e_done;
        pe       = (p == 0) ? 1 : p;
        first    = CLR + pe;
        last     = (n != 0) ? CLR + pe * n : 32'h3fff_ffff;
        end_busy = last;
        stopped  = 1'b0;
        if (stop_at != 0 && stop_at <= last) begin
            end_busy = stop_at;
            stopped  = 1'b1;
        end
        cnt = 0;
        @(negedge clk);
        period      = 8'(p);
        num_strobes = 8'(n);
        start       = 1'b1;
        stop        = 1'b0;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            strb   = (c >= first) && (c <= end_busy) && (((c - first) % pe) == 0);
            if (strb) cnt++;
            e_clr  = !((c <= CLR) && (c <= end_busy));
            e_busy = (c <= end_busy);
            e_done = !stopped && (n != 0) && (c == last + 1);
            check($sformatf("%s c%0d", name, c),
                  {20'd0, enable, clear_n, busy, done, strobe_cnt},
                  {20'd0, strb, e_clr, e_busy, e_done, 8'(cnt)});
            start = (dist_at != 0) && (c == dist_at);
            stop  = (c == stop_at);
            if (dist_at != 0 && c == dist_at) begin
                period      = 8'd7;
                num_strobes = 8'd1;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        period      = 8'd0;
        num_strobes = 8'd0;
        repeat (2) @(negedge clk);
        check("reset", {27'd0, enable, clear_n, busy, done, |strobe_cnt}, 32'b01000);
        reset_n = 1'b1;
        @(negedge clk);

        run_seq("t1_p3_n4", 3, 4, 0, 0, 18);
        run_seq("t2_p0_n3", 0, 3, 0, 0, 9);
        run_seq("t3_cont_stop", 4, 0, 20, 0, 24);
        run_seq("stop_on_strobe", 3, 4, 8, 0, 11);
        run_seq("stop_in_clear", 2, 3, 1, 0, 5);
        run_seq("t6_restart_ign", 3, 4, 0, 6, 18);

        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("t4_start_stop c%0d", c),
                  {29'd0, enable, clear_n, busy}, 32'b010);
        end
        start = 1'b0;
        stop  = 1'b0;

        run_seq("t5_pre_reset", 3, 0, 0, 0, 9);
        #1 reset_n = 1'b0;
        #1 check("t5_async_reset", {20'd0, enable, clear_n, busy, done, strobe_cnt},
                 {20'd0, 4'b0100, 8'd0});
        @(negedge clk);
        reset_n = 1'b1;
        run_seq("t5_restart", 3, 4, 0, 0, 18);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
